// File: rtl/regfile_mp_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
package regfile_mp_pkg;

  // Width of one byte lane; data width must be a multiple of this.
  localparam int BYTE_W         = 8;

  // Default geometry of the register file.
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NRD        = 2;

  // Width of the state encoding below.
  localparam int STATE_W        = 1;

  // CLEAR sweeps the array to zero after reset; RUN is normal operation.
  typedef enum logic [STATE_W-1:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_byte_merge.sv
// Combinational per-byte merge of an old word with two write words.
// Port 1 wins on bytes enabled by both ports.
module regfile_byte_merge
  import regfile_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NBYTE      = DATA_WIDTH / BYTE_W
) (
  input  logic [DATA_WIDTH-1:0] old_i,
  input  logic [DATA_WIDTH-1:0] wd0_i,
  input  logic [NBYTE-1:0]      be0_i,
  input  logic [DATA_WIDTH-1:0] wd1_i,
  input  logic [NBYTE-1:0]      be1_i,
  output logic [DATA_WIDTH-1:0] merged_o
);

  // Apply port 0 then port 1 per byte so port 1 overrides on overlap.
  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < NBYTE; b++) begin
      if (be0_i[b]) merged_o[b*BYTE_W +: BYTE_W] = wd0_i[b*BYTE_W +: BYTE_W];
      if (be1_i[b]) merged_o[b*BYTE_W +: BYTE_W] = wd1_i[b*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with byte enables, write-first
// registered reads, a post-reset clear sweep, and one address diverted
// to a PC write strobe instead of the array.
//
// Handshake: there is no valid/ready flow control on the ports. ready is
// a level: while low, writes are dropped and reads return zero; once high
// it stays high until the next reset, and every write is accepted on the
// edge where its enable is sampled.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NRD        = DEF_NRD,
  parameter int PC_ADDR    = (1 << ADDR_WIDTH) - 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NRD*ADDR_WIDTH-1:0]      rd_addr,
  output logic [NRD*DATA_WIDTH-1:0]      rd_data,
  input  logic                           we0,
  input  logic [ADDR_WIDTH-1:0]          wa0,
  input  logic [DATA_WIDTH-1:0]          wd0,
  input  logic [DATA_WIDTH/BYTE_W-1:0]   wbe0,
  input  logic                           we1,
  input  logic [ADDR_WIDTH-1:0]          wa1,
  input  logic [DATA_WIDTH-1:0]          wd1,
  input  logic [DATA_WIDTH/BYTE_W-1:0]   wbe1,
  output logic                           pc_we,
  output logic [DATA_WIDTH-1:0]          pc_wd,
  output logic                           ready,
  output rf_state_e                      dbg_state_o
);

  localparam int                    DEPTH = 1 << ADDR_WIDTH;
  localparam int                    NBYTE = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] PC_A  = ADDR_WIDTH'(PC_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  rf_state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [NRD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                     pc_we_q, pc_we_d;
  logic [DATA_WIDTH-1:0]    pc_wd_q, pc_wd_d;

  logic                     run;
  logic                     w0_act, w1_act, pc_hit0, pc_hit1;
  logic [NBYTE-1:0]         wbe0_eff, wbe1_eff;
  logic [NBYTE-1:0]         wp0_be1, wp1_be0;
  logic [DATA_WIDTH-1:0]    wmerge0, wmerge1;

  assign run         = (state_q == ST_RUN);
  assign ready       = run;
  assign dbg_state_o = state_q;
  assign rd_data     = rd_data_q;
  assign pc_we       = pc_we_q;
  assign pc_wd       = pc_wd_q;

  // Array writes are live only in RUN and never for the PC address.
  assign w0_act   = run && we0 && (wa0 != PC_A);
  assign w1_act   = run && we1 && (wa1 != PC_A);
  assign pc_hit0  = run && we0 && (wa0 == PC_A);
  assign pc_hit1  = run && we1 && (wa1 == PC_A);
  assign wbe0_eff = w0_act ? wbe0 : '0;
  assign wbe1_eff = w1_act ? wbe1 : '0;

  // Each write path folds in the other port's bytes when addresses match,
  // so both paths produce the same merged word on a shared address.
  assign wp0_be1 = (wa1 == wa0) ? wbe1_eff : '0;
  assign wp1_be0 = (wa0 == wa1) ? wbe0_eff : '0;

  regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH), .NBYTE(NBYTE)) u_wmerge0 (
    .old_i    (mem_q[wa0]),
    .wd0_i    (wd0),
    .be0_i    (wbe0_eff),
    .wd1_i    (wd1),
    .be1_i    (wp0_be1),
    .merged_o (wmerge0)
  );

  regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH), .NBYTE(NBYTE)) u_wmerge1 (
    .old_i    (mem_q[wa1]),
    .wd0_i    (wd0),
    .be0_i    (wp1_be0),
    .wd1_i    (wd1),
    .be1_i    (wbe1_eff),
    .merged_o (wmerge1)
  );

  // Per read port: write-first bypass through its own merge instance.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [NBYTE-1:0]      rbe0, rbe1;
    logic [DATA_WIDTH-1:0] rmerge;

    assign ra   = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rbe0 = (wa0 == ra) ? wbe0_eff : '0;
    assign rbe1 = (wa1 == ra) ? wbe1_eff : '0;

    regfile_byte_merge #(.DATA_WIDTH(DATA_WIDTH), .NBYTE(NBYTE)) u_rmerge (
      .old_i    (mem_q[ra]),
      .wd0_i    (wd0),
      .be0_i    (rbe0),
      .wd1_i    (wd1),
      .be1_i    (rbe1),
      .merged_o (rmerge)
    );

    assign rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] =
      (run && (ra != PC_A)) ? rmerge : '0;
  end

  // PC strobe: port 1 wins when both ports target the PC address.
  always_comb begin
    pc_we_d = pc_hit0 || pc_hit1;
    pc_wd_d = pc_wd_q;
    if (pc_hit1)      pc_wd_d = wd1;
    else if (pc_hit0) pc_wd_d = wd0;
  end

  // Next-state logic: CLEAR walks every address once, then RUN forever.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = ST_RUN;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      rd_data_q <= '0;
      pc_we_q   <= 1'b0;
      pc_wd_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      pc_we_q   <= pc_we_d;
      pc_wd_q   <= pc_wd_d;
    end
  end

  // Array storage: zeroed by the CLEAR sweep only, otherwise byte writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (w0_act) mem_q[wa0] <= wmerge0;
        if (w1_act) mem_q[wa1] <= wmerge1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic checked
// against a byte-level array model of the register file.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NRD   = 2;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int PC    = DEPTH - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic              we0, we1;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic [NB-1:0]     wbe0, wbe1;
  logic              pc_we;
  logic [DW-1:0]     pc_wd;
  logic              ready;
  rf_state_e         dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_pc_wd;
  logic          exp_pc_we;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NRD(NRD)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .we0         (we0),
    .wa0         (wa0),
    .wd0         (wd0),
    .wbe0        (wbe0),
    .we1         (we1),
    .wa1         (wa1),
    .wd1         (wd1),
    .wbe1        (wbe1),
    .pc_we       (pc_we),
    .pc_wd       (pc_wd),
    .ready       (ready),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rd_port(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  function automatic logic [AW-1:0] ra_port(input int k);
    return rd_addr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (int'(a) == PC) ? '0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Byte-enabled write into the model; called port 0 then port 1.
  task automatic model_write(input logic we, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, input logic [NB-1:0] wbe);
    if (we && int'(wa) != PC)
      for (int b = 0; b < NB; b++)
        if (wbe[b]) model[wa][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  // Driver tasks
  task automatic drive_idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0; wbe0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0; wbe1 = '0;
  endtask

  task automatic drive_random_writes();
    we0  = 1'b1; wa0 = AW'($urandom_range(0, DEPTH-1)); wd0 = $urandom; wbe0 = '1;
    we1  = 1'b1; wa1 = AW'($urandom_range(0, DEPTH-1)); wd1 = $urandom; wbe1 = '1;
    rd_addr = NRD*AW'($urandom);
  endtask

  // Release reset and walk through the clear sweep with dropped writes.
  task automatic run_clear(input string tag);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_random_writes();
      step();
      check($sformatf("%s_ready_c%0d", tag, i + 1), DW'(ready), DW'(i == DEPTH - 1));
      check($sformatf("%s_rd0_c%0d", tag, i + 1), rd_port(0), '0);
      check($sformatf("%s_pcwe_c%0d", tag, i + 1), DW'(pc_we), '0);
    end
    drive_idle();
    model_clear();
  endtask

  // Read every address through both ports and compare with the model.
  task automatic read_all(input string tag, input int last);
    for (int a = 0; a <= last; a++) begin
      rd_addr[0 +: AW]  = AW'(a);
      rd_addr[AW +: AW] = AW'(last - a);
      step();
      check($sformatf("%s_p0_r%0d", tag, a), rd_port(0), model_read(AW'(a)));
      check($sformatf("%s_p1_r%0d", tag, last - a), rd_port(1), model_read(AW'(last - a)));
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0;
    drive_idle();
    exp_pc_wd = '0;

    // Reset state
    step();
    check("rst_ready", DW'(ready), '0);
    check("rst_rd0", rd_port(0), '0);
    check("rst_rd1", rd_port(1), '0);
    check("rst_pcwe", DW'(pc_we), '0);
    check("rst_pcwd", pc_wd, '0);

    // Clear sweep, then registers 0..14 read as zero
    run_clear("clr1");
    check("clr1_state", DW'(dbg_state), DW'(ST_RUN));
    read_all("zero", DEPTH - 2);

    // Partial byte update keeps the untouched bytes
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hAABBCCDD; wbe0 = 4'b1111;
    step();
    wd0 = 32'h11223344; wbe0 = 4'b0001;
    step();
    drive_idle();
    rd_addr[0 +: AW] = 4'd3;
    step();
    check("byte_merge_r3", rd_port(0), 32'hAABBCC44);
    model[3] = 32'hAABBCC44;

    // Same-cycle dual write to r5 with a same-cycle read of r5
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h11111111; wbe0 = 4'b1111;
    we1 = 1'b1; wa1 = 4'd5; wd1 = 32'h22222222; wbe1 = 4'b0011;
    rd_addr[0 +: AW] = 4'd5;
    step();
    check("bypass_prio_r5", rd_port(0), 32'h11112222);
    drive_idle();
    step();
    check("stored_r5", rd_port(0), 32'h11112222);
    model[5] = 32'h11112222;

    // PC diversion: one-cycle strobe, array untouched
    we1 = 1'b1; wa1 = 4'd15; wd1 = 32'h00000100; wbe1 = 4'b0000;
    rd_addr[0 +: AW] = 4'd15;
    step();
    check("pc_we_hi", DW'(pc_we), 32'd1);
    check("pc_wd_val", pc_wd, 32'h00000100);
    check("pc_rd_bypass", rd_port(0), '0);
    drive_idle();
    step();
    check("pc_we_lo", DW'(pc_we), '0);
    check("pc_wd_hold", pc_wd, 32'h00000100);
    check("pc_rd_r15", rd_port(0), '0);
    exp_pc_wd = 32'h00000100;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we0  = 1'($urandom_range(0, 1)); wa0 = AW'($urandom_range(0, DEPTH-1));
      wd0  = $urandom;                wbe0 = NB'($urandom_range(0, (1 << NB) - 1));
      we1  = 1'($urandom_range(0, 1)); wa1 = AW'($urandom_range(0, DEPTH-1));
      wd1  = $urandom;                wbe1 = NB'($urandom_range(0, (1 << NB) - 1));
      if ($urandom_range(0, 3) == 0) wa1 = wa0;
      rd_addr = NRD*AW'($urandom);
      if ($urandom_range(0, 2) == 0) rd_addr[0 +: AW] = wa0;
      model_write(we0, wa0, wd0, wbe0);
      model_write(we1, wa1, wd1, wbe1);
      for (int k = 0; k < NRD; k++) exp_q.push_back(model_read(ra_port(k)));
      exp_pc_we = (we0 && int'(wa0) == PC) || (we1 && int'(wa1) == PC);
      if (we1 && int'(wa1) == PC)      exp_pc_wd = wd1;
      else if (we0 && int'(wa0) == PC) exp_pc_wd = wd0;
      step();
      for (int k = 0; k < NRD; k++)
        check($sformatf("rand%0d_rd%0d", n, k), rd_port(k), exp_q.pop_front());
      check($sformatf("rand%0d_pcwe", n), DW'(pc_we), DW'(exp_pc_we));
      check($sformatf("rand%0d_pcwd", n), pc_wd, exp_pc_wd);
    end
    drive_idle();

    // Reset in RUN, then again at clear counter 7
    reset = 1'b1;
    drive_random_writes();
    step();
    check("rst2_ready", DW'(ready), '0);
    check("rst2_rd0", rd_port(0), '0);
    check("rst2_pcwe", DW'(pc_we), '0);
    check("rst2_pcwd", pc_wd, '0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_random_writes();
      step();
      check($sformatf("part_ready_c%0d", i + 1), DW'(ready), '0);
    end
    reset = 1'b1;
    drive_random_writes();
    step();
    check("rst3_ready", DW'(ready), '0);
    check("rst3_rd1", rd_port(1), '0);
    run_clear("clr2");
    read_all("after_clr2", DEPTH - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 4: register address width; DEPTH = 1<<ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, 32: register width; multiple of 8; NBYTE = DATA_WIDTH/8.
REQ-003 SHALL have parameter NRD, 2: read port count, 1..4.
REQ-004 SHALL have parameter PC_ADDR, DEPTH-1: address diverted to the PC and not stored.
REQ-005 SHALL have clk  in  1  rising-edge clock.
REQ-006 SHALL have reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have rd_addr  in  NRD*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have rd_data  out  NRD*DATA_WIDTH  registered read data, packed like rd_addr.
REQ-009 SHALL have we0/wa0/wd0/wbe0  in  1/ADDR_WIDTH/DATA_WIDTH/NBYTE  write port 0: enable, address, data, byte enables.
REQ-010 SHALL have we1/wa1/wd1/wbe1  in  1/ADDR_WIDTH/DATA_WIDTH/NBYTE  write port 1, same layout.
REQ-011 SHALL have pc_we  out  1  one-cycle PC write strobe.
REQ-012 SHALL have pc_wd  out  DATA_WIDTH  PC write data.
REQ-013 SHALL have ready  out  1  high when clearing is done and the array is usable.

Function
REQ-014 SHALL run a two-state FSM: CLEAR and RUN.
REQ-015 CLEAR: one address per cycle, 0..DEPTH-1, written to all-zero; last address -> RUN; ready=0.
REQ-016 RUN SHALL be held until reset; ready=1.
REQ-017 Writes in CLEAR SHALL be dropped; rd_data SHALL read 0.
REQ-018 RUN write: byte b of entry wa updates when weN & wbeN[b]; all other bytes keep their value.
REQ-019 Both ports writing the same address SHALL merge per byte; port 1 wins on overlapping bytes.
REQ-020 Read latency SHALL be one cycle: rd_data reflects rd_addr sampled on the same edge.
REQ-021 Reads SHALL be write-first: a same-cycle write to the read address returns byte-merged new data.
REQ-022 All NRD ports SHALL be independent; any ports may share an address.
REQ-023 Writes to PC_ADDR SHALL not touch the array.
REQ-024 A PC_ADDR write SHALL give pc_we=1 the next cycle, with pc_wd = full wd of the winning port (port 1 if both); wbe ignored.
REQ-025 Reads of PC_ADDR SHALL return 0.
REQ-026 pc_we SHALL be suppressed in CLEAR.

Reset
REQ-027 Reset SHALL force CLEAR with counter=0 and ready=0, including mid-CLEAR (restart) and mid-RUN.
REQ-028 Reset SHALL give rd_data=0, pc_we=0, pc_wd=0 on the next edge.
REQ-029 ready SHALL rise exactly DEPTH cycles after reset deasserts.
REQ-030 Register contents are not otherwise reset; the CLEAR sweep is the only initialisation.

Structure
REQ-031 FULLW/WIDTH-style width constants and the CLEAR/RUN state encoding SHALL live in the shared defines package.
REQ-032 One sub-module SHALL exist: regfile_byte_merge, combinational per-byte merge of old/wd0/wd1 under wbe0/wbe1 with port-1 priority.
REQ-033 It SHALL be instantiated once per write path and once per read-bypass path.

Verification
REQ-034 Reset 1 cycle, then release -> ready=0 for 16 cycles, ready=1 on cycle 16; reads of r0..r14 = 0.
REQ-035 we0=1, wa0=3, wd0=32'hAABBCCDD, wbe0=4'b1111, then wbe0=4'b0001 with wd0=32'h11223344 -> read r3 = 32'hAABBCC44.
REQ-036 Same cycle: we0 to r5, wd 32'h11111111, wbe 4'b1111, plus we1 to r5, wd 32'h22222222, wbe 4'b0011; rd_addr port0=5 -> next-cycle rd_data = 32'h11112222, proving bypass and priority.
REQ-037 we1=1, wa1=15, wd1=32'h00000100 -> pc_we=1 for exactly one cycle, pc_wd=32'h00000100; read r15 = 0.
REQ-038 Reset asserted at clear counter 7, then released -> ready rises 16 cycles after release; writes attempted during CLEAR are absent afterwards.
